router_mux4: RTL and testbench

- Output-side packet multiplexer of a 4-port router; one instance per output port, selected by parameter PortNo.
- Each of 4 input streams carries a destination tag. Packets tagged for PortNo are arbitrated (round-robin, packet-atomic) onto a single registered output stream.
- Per-input backpressure (D_BP) and a collision flag (COLLISION) report contention.

---
 rtl/router_mux4_if.sv | 33 +++
 rtl/router_mux4.sv | 123 ++++++++++++
 tb/tb_router_mux4.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_mux4_if.sv
// router_mux4_if: input streams, downstream backpressure and
// the registered output stream of one router output port.
interface router_mux4_if;
   logic [3:0][63:0] D;
   logic [3:0][7:0]  DEST;
   logic [3:0]       DEST_VALID;
   logic [3:0]       D_HDR_VALID;
   logic [3:0]       D_PLD_VALID;
   logic [3:0]       D_SOF;
   logic [3:0]       D_EOF;
   logic [3:0]       Q_BP;
   logic [3:0]       D_BP;
   logic             COLLISION;
   logic [63:0]      Q;
   logic             Q_HDR_VALID;
   logic             Q_PLD_VALID;
   logic             Q_SOF;
   logic             Q_EOF;

   modport master (
      output D, DEST, DEST_VALID, D_HDR_VALID,
      output D_PLD_VALID, D_SOF, D_EOF, Q_BP,
      input  D_BP, COLLISION, Q,
      input  Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF
   );

   modport slave (
      input  D, DEST, DEST_VALID, D_HDR_VALID,
      input  D_PLD_VALID, D_SOF, D_EOF, Q_BP,
      output D_BP, COLLISION, Q,
      output Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF
   );
endinterface

// File: rtl/router_mux4.sv
// router_mux4: round-robin, packet-atomic output multiplexer
// for one output port of a 4-port router.
module router_mux4 #(
   parameter int Numports = 4,
   parameter int PortNo   = 0
) (
   input logic        CLK,
   input logic        RST,
   router_mux4_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [7:0] PORT_ID = 8'(PortNo);

   state_t      state;
   logic [1:0]  g;
   logic [1:0]  rr;
   logic [63:0] q_r;
   logic        hdr_r;
   logic        pld_r;
   logic        sof_r;
   logic        eof_r;
   logic        col_r;

   logic [3:0]  req;
   logic [3:0]  cand;
   logic [1:0]  win;
   logic        any_cand;
   logic        multi;
   logic        other_sof;
   logic [1:0]  gsel;
   logic        gact;
   logic [3:0]  gvec;
   logic        stall;
   logic        fwd;
   logic        rel;

   // Request decode and round-robin pick among SOF candidates
   always_comb begin
      logic [1:0] idx;
      req      = '0;
      win      = rr;
      any_cand = 1'b0;
      idx      = '0;
      for (int i = 0; i < Numports; i++) begin
         req[i] = bus.DEST_VALID[i] & (bus.DEST[i] == PORT_ID);
      end
      cand = req & bus.D_SOF;
      // scan from farthest offset down so the nearest to rr wins
      for (int k = Numports - 1; k >= 0; k--) begin
         idx = rr + 2'(k);
         if (cand[idx]) begin
            win      = idx;
            any_cand = 1'b1;
         end
      end
   end

   assign multi     = |(cand & (cand - 4'd1));
   assign other_sof = |(cand & ~(4'b0001 << g));
   assign stall     = |bus.Q_BP;
   assign gsel      = (state == BUSY) ? g : win;
   // reset masks the grant so sources only see their own request
   assign gact      = RST & ((state == BUSY) | any_cand);
   assign gvec      = gact ? (4'b0001 << gsel) : 4'b0000;
   assign fwd       = gact & ~stall;
   assign rel       = (state == BUSY) & ~stall &
                      ((bus.D_EOF[g] &
                        (bus.D_HDR_VALID[g] | bus.D_PLD_VALID[g])) |
                       ~bus.DEST_VALID[g]);

   assign bus.D_BP        = req & ~(gvec & {4{~stall}});
   assign bus.Q           = q_r;
   assign bus.Q_HDR_VALID = hdr_r;
   assign bus.Q_PLD_VALID = pld_r;
   assign bus.Q_SOF       = sof_r;
   assign bus.Q_EOF       = eof_r;
   assign bus.COLLISION   = col_r;

   // Grant FSM, registered output stream and collision flag
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= IDLE;
         g     <= '0;
         rr    <= '0;
         q_r   <= '0;
         hdr_r <= 1'b0;
         pld_r <= 1'b0;
         sof_r <= 1'b0;
         eof_r <= 1'b0;
         col_r <= 1'b0;
      end else begin
         if (fwd) begin
            q_r   <= bus.D[gsel];
            hdr_r <= bus.D_HDR_VALID[gsel];
            pld_r <= bus.D_PLD_VALID[gsel];
            sof_r <= bus.D_SOF[gsel];
            eof_r <= bus.D_EOF[gsel];
         end else begin
            hdr_r <= 1'b0;
            pld_r <= 1'b0;
            sof_r <= 1'b0;
            eof_r <= 1'b0;
         end
         col_r <= (state == IDLE) ? multi : other_sof;
         unique case (state)
            IDLE: begin
               if (any_cand) begin
                  g     <= win;
                  rr    <= win + 2'd1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (rel) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_mux4.sv
// tb_router_mux4: directed scoreboard bench for router_mux4
// configured as output port 1.
module tb_router_mux4;

   typedef struct packed {
      logic [63:0] q;
      logic [3:0]  qual;
      logic        col;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   exp_t        sbq[$];
   logic [63:0] hold_q;
   logic [3:0]  rq;
   int          checks;
   int          errors;

   always #5 CLK = ~CLK;

   router_mux4_if bus ();

   router_mux4 #(
      .Numports(4),
      .PortNo  (1)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic clr_in();
      bus.D           = '0;
      bus.DEST        = '0;
      bus.DEST_VALID  = '0;
      bus.D_HDR_VALID = '0;
      bus.D_PLD_VALID = '0;
      bus.D_SOF       = '0;
      bus.D_EOF       = '0;
      bus.Q_BP        = '0;
   endtask

   task automatic send(int i, logic [7:0] dst, logic [63:0] d,
                       logic h, logic p, logic s, logic e);
      bus.DEST_VALID[i]  = 1'b1;
      bus.DEST[i]        = dst;
      bus.D[i]           = d;
      bus.D_HDR_VALID[i] = h;
      bus.D_PLD_VALID[i] = p;
      bus.D_SOF[i]       = s;
      bus.D_EOF[i]       = e;
   endtask

   task automatic idle_in(int i);
      bus.DEST_VALID[i]  = 1'b0;
      bus.D_HDR_VALID[i] = 1'b0;
      bus.D_PLD_VALID[i] = 1'b0;
      bus.D_SOF[i]       = 1'b0;
      bus.D_EOF[i]       = 1'b0;
   endtask

   task automatic efwd(logic [63:0] d, logic [3:0] qual, logic col);
      exp_t x;
      hold_q = d;
      x.q    = d;
      x.qual = qual;
      x.col  = col;
      sbq.push_back(x);
   endtask

   task automatic enone(logic col);
      exp_t x;
      x.q    = hold_q;
      x.qual = 4'b0000;
      x.col  = col;
      sbq.push_back(x);
   endtask

   task automatic step(string tag, logic [3:0] exp_bp);
      exp_t e;
      #1;
      chk({tag, ".bp"}, 64'(bus.D_BP), 64'(exp_bp));
      @(posedge CLK);
      #1;
      checks++;
      assert (sbq.size() > 0) else begin
         errors++;
         $error("FAIL %s.sb obs=empty exp=entry", tag);
      end
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk({tag, ".q"}, bus.Q, e.q);
         chk({tag, ".qual"},
             64'({bus.Q_HDR_VALID, bus.Q_PLD_VALID,
                  bus.Q_SOF, bus.Q_EOF}),
             64'(e.qual));
         chk({tag, ".col"}, 64'(bus.COLLISION), 64'(e.col));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      hold_q = '0;
      RST    = 1'b0;
      clr_in();

      // reset with random inputs: outputs 0, D_BP == req
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 4; i++) begin
            bus.D[i]           = {$urandom, $urandom};
            bus.DEST[i]        = 8'($urandom_range(0, 3));
            bus.DEST_VALID[i]  = 1'($urandom);
            bus.D_HDR_VALID[i] = 1'($urandom);
            bus.D_PLD_VALID[i] = 1'($urandom);
            bus.D_SOF[i]       = 1'($urandom);
            bus.D_EOF[i]       = 1'($urandom);
            rq[i] = bus.DEST_VALID[i] & (bus.DEST[i] == 8'd1);
         end
         bus.Q_BP = 4'($urandom);
         enone(1'b0);
         step("rst", rq);
      end

      RST = 1'b1;
      clr_in();
      for (int c = 0; c < 2; c++) begin
         enone(1'b0);
         step("post_rst", 4'b0000);
      end

      // single packet on input 0
      send(0, 8'd1, {8'h1, 56'h1}, 1'b1, 1'b0, 1'b1, 1'b0);
      efwd({8'h1, 56'h1}, 4'b1010, 1'b0);
      step("p0.sof", 4'b0000);
      for (int v = 1; v <= 10; v++) begin
         send(0, 8'd1, 64'(v), 1'b0, 1'b1, 1'b0, v == 10);
         efwd(64'(v), {2'b01, 1'b0, v == 10}, 1'b0);
         step("p0.pld", 4'b0000);
      end
      idle_in(0);
      enone(1'b0);
      step("p0.end", 4'b0000);

      // wrong destination on input 2
      send(2, 8'd3, 64'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0);
      enone(1'b0);
      step("wd.sof", 4'b0000);
      send(2, 8'd3, 64'h5, 1'b0, 1'b1, 1'b0, 1'b1);
      enone(1'b0);
      step("wd.eof", 4'b0000);
      idle_in(2);

      // fresh reset so rr starts at 0
      RST = 1'b0;
      clr_in();
      hold_q = '0;
      enone(1'b0);
      step("rst2", 4'b0000);
      RST = 1'b1;

      // simultaneous SOF on 0 and 1: input 0 wins
      send(0, 8'd1, 64'hA0, 1'b1, 1'b0, 1'b1, 1'b0);
      send(1, 8'd1, 64'hB0, 1'b1, 1'b0, 1'b1, 1'b0);
      efwd(64'hA0, 4'b1010, 1'b1);
      step("c.sof", 4'b0010);
      bus.D_SOF[1] = 1'b0;
      for (int v = 1; v <= 3; v++) begin
         send(0, 8'd1, 64'(v), 1'b0, 1'b1, 1'b0, v == 3);
         efwd(64'(v), {2'b01, 1'b0, v == 3}, 1'b0);
         step("c.pld", 4'b0010);
      end
      idle_in(0);
      idle_in(1);
      enone(1'b0);
      step("c.drop", 4'b0000);

      // simultaneous SOF again: rr=1 so input 1 wins
      send(0, 8'd1, 64'hA1, 1'b1, 1'b0, 1'b1, 1'b0);
      send(1, 8'd1, 64'd16, 1'b0, 1'b1, 1'b1, 1'b0);
      efwd(64'd16, 4'b0110, 1'b1);
      step("rr.sof", 4'b0001);
      bus.D_SOF[0] = 1'b0;
      for (int v = 2; v <= 10; v++) begin
         send(1, 8'd1, 64'(16 * v), 1'b0, 1'b1, 1'b0, v == 10);
         efwd(64'(16 * v), {2'b01, 1'b0, v == 10}, 1'b0);
         step("rr.pld", 4'b0001);
      end
      idle_in(0);
      idle_in(1);
      enone(1'b0);
      step("rr.drop", 4'b0000);

      // stall mid-payload on input 2
      send(2, 8'd1, 64'hC0, 1'b1, 1'b0, 1'b1, 1'b0);
      efwd(64'hC0, 4'b1010, 1'b0);
      step("st.sof", 4'b0000);
      for (int v = 1; v <= 2; v++) begin
         send(2, 8'd1, 64'(v), 1'b0, 1'b1, 1'b0, 1'b0);
         efwd(64'(v), 4'b0100, 1'b0);
         step("st.pld", 4'b0000);
      end
      send(2, 8'd1, 64'd3, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.Q_BP = 4'b0001;
      for (int c = 0; c < 2; c++) begin
         enone(1'b0);
         step("st.stall", 4'b0100);
      end
      bus.Q_BP = 4'b0000;
      efwd(64'd3, 4'b0100, 1'b0);
      step("st.resume", 4'b0000);
      send(2, 8'd1, 64'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      efwd(64'd4, 4'b0100, 1'b0);
      step("st.pld4", 4'b0000);

      // abort input 2 while input 3 presents SOF
      idle_in(2);
      send(3, 8'd1, 64'hD0, 1'b1, 1'b0, 1'b1, 1'b0);
      efwd(64'd4, 4'b0000, 1'b1);
      step("ab.rel", 4'b1000);
      efwd(64'hD0, 4'b1010, 1'b0);
      step("ab.next", 4'b0000);
      send(3, 8'd1, 64'h77, 1'b0, 1'b1, 1'b0, 1'b1);
      efwd(64'h77, 4'b0101, 1'b0);
      step("ab.eof", 4'b0000);
      idle_in(3);
      enone(1'b0);
      step("ab.end", 4'b0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
